// File: rtl/adc_muestreo.sv
// adc_muestreo: paces a 12-bit unipolar serial ADC at a fixed sample rate and
// converts each code to a signed Q8.14 sample with a one-cycle strobe.
module adc_muestreo #(
    parameter int unsigned ancho_p         = 23,
    parameter int unsigned fraccion        = 14,
    parameter int unsigned div_sclk        = 4,
    parameter int unsigned periodo_muestra = 2272
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               habilitar,
    input  logic               sdata,
    output logic               cs_n,
    output logic               sclk,
    output logic [ancho_p-1:0] muestra,
    output logic               en
);

    localparam int unsigned ANCHO_CNT = $clog2(periodo_muestra);
    localparam int unsigned ANCHO_DIV = $clog2(div_sclk + 1);
    localparam int unsigned DESP      = fraccion - 11;

    localparam logic [1:0] ESPERA = 2'd0;
    localparam logic [1:0] CONV   = 2'd1;
    localparam logic [1:0] FIN    = 2'd2;

    logic [1:0]           estado_q, estado_d;
    logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
    logic [ANCHO_DIV-1:0] fase_q, fase_d;
    logic [3:0]           bits_q, bits_d;
    logic [11:0]          sr_q, sr_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic [ancho_p-1:0]   muestra_q, muestra_d;
    logic                 en_q, en_d;

    logic                 tick;
    logic [11:0]          s;
    logic [ancho_p-1:0]   ext;
    logic [ancho_p-1:0]   convertido;

    assign tick = habilitar && (cnt_q == ANCHO_CNT'(periodo_muestra - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!habilitar || tick) begin
            cnt_d = '0;
        end
    end

    // Offset-binary to two's complement is just an MSB flip.
    assign s          = {~sr_q[11], sr_q[10:0]};
    assign ext        = {{(ancho_p - 12){s[11]}}, s};
    assign convertido = ext << DESP;

    always_comb begin
        estado_d  = estado_q;
        fase_d    = fase_q;
        bits_d    = bits_q;
        sr_d      = sr_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        muestra_d = muestra_q;
        en_d      = 1'b0;
        unique case (estado_q)
            ESPERA: begin
                if (tick) begin
                    estado_d = CONV;
                    cs_n_d   = 1'b0;
                    sclk_d   = 1'b0;
                    fase_d   = '0;
                    bits_d   = '0;
                end
            end
            CONV: begin
                if (fase_q == ANCHO_DIV'(div_sclk - 1)) begin
                    fase_d = '0;
                    if (!sclk_q) begin
                        // 12-bit shifter: the four leading frame bits fall off the top.
                        sclk_d = 1'b1;
                        sr_d   = {sr_q[10:0], sdata};
                    end else if (bits_q == 4'd15) begin
                        estado_d  = FIN;
                        cs_n_d    = 1'b1;
                        en_d      = 1'b1;
                        muestra_d = convertido;
                    end else begin
                        sclk_d = 1'b0;
                        bits_d = bits_q + 1'b1;
                    end
                end else begin
                    fase_d = fase_q + 1'b1;
                end
            end
            FIN: begin
                estado_d = ESPERA;
            end
            default: begin
                estado_d = ESPERA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q  <= ESPERA;
            cnt_q     <= '0;
            fase_q    <= '0;
            bits_q    <= '0;
            sr_q      <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            muestra_q <= '0;
            en_q      <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            fase_q    <= fase_d;
            bits_q    <= bits_d;
            sr_q      <= sr_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            muestra_q <= muestra_d;
            en_q      <= en_d;
        end
    end

    assign cs_n    = cs_n_q;
    assign sclk    = sclk_q;
    assign muestra = muestra_q;
    assign en      = en_q;

endmodule
